// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: march-test BIST initiator for a small single-port RAM.
// Runs write / read-check / inverted-write / read-check over every address
// and reports pass, a saturating error count and the first failing word.
module ram_bist_ctrl #(
    parameter int                 ADDR_W  = 4,
    parameter int                 DATA_W  = 8,
    parameter logic [DATA_W-1:0]  PATTERN = 8'hA5,
    parameter int                 RD_LAT  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [7:0]        err_count,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic              we,
    output logic              re,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] din,
    input  logic [DATA_W-1:0] dout
);

    localparam int                DEPTH      = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ADDR_MAX   = ADDR_W'(DEPTH - 1);
    localparam logic [1:0]        DRAIN_LAST = 2'(RD_LAT - 1);

    typedef enum logic [2:0] {
        IDLE,
        W_ASC,
        R_ASC,
        W_DSC,
        R_DSC,
        FIN
    } state_t;

    state_t            state;
    logic [1:0]        drain_cnt;

    // Read-check pipeline: one entry per issued read, aligned with dout.
    logic [RD_LAT-1:0] pipe_valid;
    logic [ADDR_W-1:0] pipe_addr [RD_LAT];
    logic [DATA_W-1:0] pipe_exp  [RD_LAT];

    logic [DATA_W-1:0] exp_now;
    logic              hit;
    logic [7:0]        err_next;

    // Background pattern for a word: seed XOR its (resized) address.
    function automatic logic [DATA_W-1:0] data_of(input logic [ADDR_W-1:0] a);
        return PATTERN ^ DATA_W'(a);
    endfunction

    // Expected read value for the address on the bus, and the compare at the pipe tail.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        exp_now  = data_of(addr);
        hit      = 1'b0;
        err_next = err_count;
        if (state == R_DSC) begin
            exp_now = ~data_of(addr);
        end
        if (pipe_valid[RD_LAT-1] && (dout != pipe_exp[RD_LAT-1])) begin
            hit = 1'b1;
        end
        if (hit && (err_count != 8'hFF)) begin
            err_next = err_count + 8'd1;
        end
    end

    // Valid bits of the check pipeline: a registered re pushes an entry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pipe_valid <= '0;
        end else begin
            pipe_valid[0] <= re;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
            end
        end
    end

    // Address/expected payload of the check pipeline.
    always_ff @(posedge clk) begin
        // NOTE: payload registers carry no reset; they are only consumed behind their valid bit.
        pipe_addr[0] <= addr;
        pipe_exp[0]  <= exp_now;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_addr[i] <= pipe_addr[i-1];
            pipe_exp[i]  <= pipe_exp[i-1];
        end
    end

    // Main sequencer: phase control, RAM strobes, result registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            state     <= IDLE;
            drain_cnt <= 2'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= 8'd0;
            fail_addr <= '0;
            fail_data <= '0;
            we        <= 1'b0;
            re        <= 1'b0;
            addr      <= '0;
            din       <= '0;
        end else begin
            err_count <= err_next;
            if (hit && (err_count == 8'd0)) begin
                fail_addr <= pipe_addr[RD_LAT-1];
                fail_data <= dout;
            end

            case (state)
                IDLE: begin
                    we   <= 1'b0;
                    re   <= 1'b0;
                    done <= 1'b0;
                    if (start) begin
                        err_count <= 8'd0;
                        fail_addr <= '0;
                        fail_data <= '0;
                        pass      <= 1'b0;
                        busy      <= 1'b1;
                        we        <= 1'b1;
                        addr      <= '0;
                        din       <= data_of('0);
                        state     <= W_ASC;
                    end
                end

                W_ASC: begin
                    if (addr == ADDR_MAX) begin
                        we    <= 1'b0;
                        re    <= 1'b1;
                        addr  <= '0;
                        state <= R_ASC;
                    end else begin
                        addr <= addr + 1'b1;
                        din  <= data_of(addr + 1'b1);
                    end
                end

                R_ASC: begin
                    if (re) begin
                        if (addr == ADDR_MAX) begin
                            re        <= 1'b0;
                            drain_cnt <= 2'd0;
                        end else begin
                            addr <= addr + 1'b1;
                        end
                    end else if (drain_cnt == DRAIN_LAST) begin
                        we    <= 1'b1;
                        addr  <= ADDR_MAX;
                        din   <= ~data_of(ADDR_MAX);
                        state <= W_DSC;
                    end else begin
                        drain_cnt <= drain_cnt + 2'd1;
                    end
                end

                W_DSC: begin
                    if (addr == '0) begin
                        we    <= 1'b0;
                        re    <= 1'b1;
                        addr  <= ADDR_MAX;
                        state <= R_DSC;
                    end else begin
                        addr <= addr - 1'b1;
                        din  <= ~data_of(addr - 1'b1);
                    end
                end

                R_DSC: begin
                    if (re) begin
                        if (addr == '0) begin
                            re        <= 1'b0;
                            drain_cnt <= 2'd0;
                        end else begin
                            addr <= addr - 1'b1;
                        end
                    end else if (drain_cnt == DRAIN_LAST) begin
                        // The last compare lands on this edge, so pass uses err_next.
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == 8'd0);
                        state <= FIN;
                    end else begin
                        drain_cnt <= drain_cnt + 2'd1;
                    end
                end

                FIN: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    we    <= 1'b0;
                    re    <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// tb_ram_bist_ctrl: directed bench for ram_bist_ctrl with behavioural RAM
// models (1- and 2-cycle read latency) that can inject simple faults.
module tb_ram_bist_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_a, start_b;
    int         ram_mode;   // 0 clean, 1 addr 3 bit0 stuck at 1, 2 ignore writes / read 00

    logic       busy_a, done_a, pass_a, we_a, re_a;
    logic [7:0] err_a, fd_a, din_a, dout_a;
    logic [3:0] fa_a, addr_a;
    logic       busy_b, done_b, pass_b, we_b, re_b;
    logic [7:0] err_b, fd_b, din_b, dout_b;
    logic [3:0] fa_b, addr_b;

    bit         sel;
    logic       o_busy, o_done, o_pass, o_we, o_re;
    logic [7:0] o_err, o_fd, o_din;
    logic [3:0] o_fa, o_addr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_bist_ctrl #(.RD_LAT(1)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .err_count(err_a), .fail_addr(fa_a), .fail_data(fd_a),
        .we(we_a), .re(re_a), .addr(addr_a), .din(din_a), .dout(dout_a)
    );

    ram_bist_ctrl #(.RD_LAT(2)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .err_count(err_b), .fail_addr(fa_b), .fail_data(fd_b),
        .we(we_b), .re(re_b), .addr(addr_b), .din(din_b), .dout(dout_b)
    );

    assign o_busy = sel ? busy_b : busy_a;
    assign o_done = sel ? done_b : done_a;
    assign o_pass = sel ? pass_b : pass_a;
    assign o_we   = sel ? we_b   : we_a;
    assign o_re   = sel ? re_b   : re_a;
    assign o_err  = sel ? err_b  : err_a;
    assign o_fd   = sel ? fd_b   : fd_a;
    assign o_din  = sel ? din_b  : din_a;
    assign o_fa   = sel ? fa_b   : fa_a;
    assign o_addr = sel ? addr_b : addr_a;

    // RAM read path with optional fault injection.
    function automatic logic [7:0] ram_rd(input logic [7:0] w, input logic [3:0] a);
        case (ram_mode)
            1:       return (a == 4'd3) ? (w | 8'h01) : w;
            2:       return 8'h00;
            default: return w;
        endcase
    endfunction

    logic [7:0] mem_a [16];
    logic [7:0] mem_b [16];
    logic [7:0] stage_b;

    // 1-cycle RAM beside instance a.
    always @(posedge clk) begin
        if (we_a) mem_a[addr_a] <= din_a;
        if (re_a) dout_a <= ram_rd(mem_a[addr_a], addr_a);
    end

    // 2-cycle RAM beside instance b.
    always @(posedge clk) begin
        if (we_b) mem_b[addr_b] <= din_b;
        if (re_b) stage_b <= ram_rd(mem_b[addr_b], addr_b);
        dout_b <= stage_b;
    end

    typedef struct packed {
        logic [3:0] a;
        logic [7:0] d;
    } wr_t;
    wr_t wr_q[$];

    typedef struct {
        bit         sel;
        int         mode;
        int         blen;
        logic [7:0] err;
        logic [3:0] fa;
        logic [7:0] fd;
        bit         pass;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_start(input bit s, input logic v);
        if (s) start_b = v;
        else   start_a = v;
    endtask

    // Pulse start, then watch a fixed 90-cycle window sampled on falling edges.
    task automatic run(input int extra_at, output int blen, output int dones, output int both);
        wr_q.delete();
        blen  = 0;
        dones = 0;
        both  = 0;
        drive_start(sel, 1'b1);
        @(negedge clk);
        drive_start(sel, 1'b0);
        for (int i = 0; i < 90; i++) begin
            if (o_busy) blen++;
            if (o_done) dones++;
            if (o_we && o_re) both++;
            if (o_we) wr_q.push_back({o_addr, o_din});
            if (i == extra_at) drive_start(sel, 1'b1);
            else if (i == extra_at + 1) drive_start(sel, 1'b0);
            @(negedge clk);
        end
    endtask

    initial begin
        int blen, dones, both, done_idx;
        logic [7:0] busy_after1, busy_after2;

        vecs[0] = '{sel: 0, mode: 0, blen: 66, err: 8'd0,  fa: 4'h0, fd: 8'h00, pass: 1};
        vecs[1] = '{sel: 0, mode: 1, blen: 66, err: 8'd1,  fa: 4'h3, fd: 8'hA7, pass: 0};
        vecs[2] = '{sel: 0, mode: 2, blen: 66, err: 8'd32, fa: 4'h0, fd: 8'h00, pass: 0};
        vecs[3] = '{sel: 1, mode: 0, blen: 68, err: 8'd0,  fa: 4'h0, fd: 8'h00, pass: 1};
        vecs[4] = '{sel: 1, mode: 1, blen: 68, err: 8'd1,  fa: 4'h3, fd: 8'hA7, pass: 0};

        rst = 1'b0; start_a = 1'b0; start_b = 1'b0; ram_mode = 0; sel = 0;
        repeat (3) @(negedge clk);
        check("reset flags", {busy_a, done_a, pass_a, we_a, re_a}, 5'b0);
        check("reset err/fail", {err_a, fa_a, fd_a}, 20'h0);
        check("reset addr/din", {addr_a, din_a}, 12'h0);
        rst = 1'b1;
        @(negedge clk);

        // Table-driven runs.
        for (int v = 0; v < 5; v++) begin
            sel      = vecs[v].sel;
            ram_mode = vecs[v].mode;
            run(-1, blen, dones, both);
            check($sformatf("v%0d busy_len", v), blen, vecs[v].blen);
            check($sformatf("v%0d done_cnt", v), dones, 1);
            check($sformatf("v%0d we_re_overlap", v), both, 0);
            check($sformatf("v%0d err_count", v), o_err, vecs[v].err);
            check($sformatf("v%0d fail_addr", v), o_fa, vecs[v].fa);
            check($sformatf("v%0d fail_data", v), o_fd, vecs[v].fd);
            check($sformatf("v%0d pass", v), o_pass, vecs[v].pass);
            check($sformatf("v%0d write_cnt", v), wr_q.size(), 32);
            if (v == 0) begin
                check("wr0 addr0 A5", wr_q[0], {4'h0, 8'hA5});
                check("wr1 addr1 A4", wr_q[1], {4'h1, 8'hA4});
                check("wr15 addrF AA", wr_q[15], {4'hF, 8'hAA});
                check("inv wr first F 55", wr_q[16], {4'hF, 8'h55});
                check("inv wr last 0 5A", wr_q[31], {4'h0, 8'h5A});
            end
        end

        // Second start pulse mid-run is ignored.
        sel = 0; ram_mode = 1;
        run(10, blen, dones, both);
        check("restart busy_len", blen, 66);
        check("restart done_cnt", dones, 1);
        check("restart err_count", o_err, 8'd1);
        ram_mode = 0;
        run(-1, blen, dones, both);
        check("rerun err cleared", o_err, 8'd0);
        check("rerun pass", o_pass, 1'b1);

        // start held high: one idle cycle after FIN, then a new run.
        start_a = 1'b1;
        done_idx = -1;
        busy_after1 = 8'hFF;
        busy_after2 = 8'hFF;
        @(negedge clk);
        for (int i = 0; i < 100; i++) begin
            if (done_a && done_idx < 0) done_idx = i;
            if (done_idx >= 0 && i == done_idx + 1) busy_after1 = {7'd0, busy_a};
            if (done_idx >= 0 && i == done_idx + 2) busy_after2 = {7'd0, busy_a};
            @(negedge clk);
        end
        start_a = 1'b0;
        check("held start done seen", done_idx, 66);
        check("held start idle gap", busy_after1, 8'd0);
        check("held start rerun", busy_after2, 8'd1);
        repeat (80) @(negedge clk);

        // Reset pulse during R_DSC aborts without done.
        ram_mode = 1;
        dones = 0;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int i = 0; i < 90; i++) begin
            if (done_a) dones++;
            if (i == 55) rst = 1'b0;
            if (i == 56) begin
                check("midrst flags", {busy_a, done_a, pass_a, we_a, re_a}, 5'b0);
                check("midrst err/fail", {err_a, fa_a, fd_a}, 20'h0);
                check("midrst addr/din", {addr_a, din_a}, 12'h0);
                rst = 1'b1;
            end
            @(negedge clk);
        end
        check("midrst no done", dones, 0);
        ram_mode = 0;
        run(-1, blen, dones, both);
        check("post-rst busy_len", blen, 66);
        check("post-rst pass", o_pass, 1'b1);
        check("post-rst err_count", o_err, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_bist_ctrl.md
Name: ram_bist_ctrl

Overview:
- Built-in self-test initiator for the 16x8 single-port RAM block.
- Drives the RAM's we/re/addr/din side and checks returned dout with a four-phase march sequence (write, read/check, inverted write, read/check).
- Sits beside the RAM with a mux, not part of this block, that selects BIST or functional access.
- Reports pass/fail, error count and first failing address/data to the top level.

Parameters:
- ADDR_W, 4, RAM address width; DEPTH = 2**ADDR_W.
- DATA_W, 8, RAM data width.
- PATTERN, 8'hA5, background seed; must be DATA_W bits wide.
- RD_LAT, 1, cycles from re/addr sampled by the RAM to valid dout. Legal values 1..3.

Ports:
- clk, in, 1, single clock; all logic on the rising edge.
- rst, in, 1, synchronous active-low reset.
- start, in, 1, one-cycle request to run the test; sampled only in IDLE.
- busy, out, 1, high while a test is running.
- done, out, 1, one-cycle pulse when the test completes.
- pass, out, 1, valid from the done pulse until the next start: 1 when err_count==0.
- err_count, out, 8, saturating mismatch count.
- fail_addr, out, ADDR_W, address of the first mismatch.
- fail_data, out, DATA_W, dout value at the first mismatch.
- we, out, 1, RAM write enable.
- re, out, 1, RAM read enable.
- addr, out, ADDR_W, RAM address.
- din, out, DATA_W, RAM write data.
- dout, in, DATA_W, RAM read data.

Behaviour:
- Reset (rst==0 at a clock edge), from any state including mid-test:
  - state=IDLE.
  - busy=0, done=0, pass=0, err_count=0, fail_addr=0, fail_data=0.
  - we=0, re=0, addr=0, din=0.
  - Pipeline valid bits are cleared.
- All outputs are registered.
- Expected data: D(a) = PATTERN ^ a, with a zero-extended or truncated to DATA_W.
- State sequence: IDLE -> W_ASC -> R_ASC -> W_DSC -> R_DSC -> FIN -> IDLE.
- IDLE:
  - we=re=0.
  - start=1 -> clear err_count, fail_addr, fail_data and pass; enter W_ASC with addr=0; busy goes high the same edge.
- W_ASC: DEPTH cycles.
  - we=1, addr=0..DEPTH-1 ascending, din=D(addr).
- R_ASC: DEPTH issue cycles plus RD_LAT drain cycles.
  - Issue cycles: re=1, addr ascending 0..DEPTH-1.
  - Drain cycles: re=0, addr holds.
- W_DSC: DEPTH cycles.
  - we=1, addr=DEPTH-1 descending to 0, din=~D(addr).
- R_DSC: DEPTH issue cycles (re=1, addr descending) plus RD_LAT drain cycles.
- we and re are never high together. Both are 0 in drain cycles, IDLE and FIN.
- Check pipeline:
  - Each issued read pushes {valid, addr, expected} into an RD_LAT-deep shift register.
  - When the valid entry emerges, compare dout to expected.
  - On mismatch: err_count increments, saturating at 255.
  - If this is the first mismatch of the run, latch fail_addr=addr and fail_data=dout.
  - Expected value is D(a) in R_ASC and ~D(a) in R_DSC.
- FIN: one cycle.
  - busy=0, done=1, pass=(err_count==0), counting the final compare from the last drain cycle.
  - Next state is IDLE.
- Total busy duration: 4*DEPTH + 2*RD_LAT cycles. With defaults this is 66 cycles.
  - If start is seen at edge k, busy is high from edge k through edge k+65.
  - FIN (done=1) follows at edge k+66.
- start while busy or in FIN is ignored, with no restart and no queuing.
- start held high continuously: a new run begins on the first IDLE cycle after FIN.
- Address counter wraps only at phase boundaries. The terminal address ends the phase, with no wrap into a new pass.
- Reset mid-test aborts immediately; done is not pulsed.

Test Plan:
- Clean RAM with defaults; pulse start:
  - busy lasts 66 cycles, then a done pulse.
  - pass=1, err_count=0.
  - Write sequence: addr 0 with din A5, addr 1 with din A4, ..., addr F with din AA.
  - Inverted write: addr F with din 55 first.
- RAM model with bit 0 of address 3 stuck at 1:
  - R_ASC: word 3 expected A6, read A7, mismatch.
  - R_DSC: word 3 expected 59, read 59, no mismatch.
  - Result: err_count=1, fail_addr=3, fail_data=A7, pass=0.
- RAM model ignoring writes, returning 00 everywhere:
  - err_count=32.
  - fail_addr=0, fail_data=00.
  - pass=0.
- Second start pulse at cycle 10 of a run:
  - Ignored; run length stays 66 and only one done pulse occurs.
  - A subsequent start after done reruns the test and clears err_count.
- rst=0 for one cycle during R_DSC:
  - Next cycle all outputs are 0, state is IDLE, and no done pulse occurs.
  - After rst=1 and start, a full clean 66-cycle run passes.
- RD_LAT=2 with a 2-cycle RAM model:
  - busy lasts 68 cycles, pass=1.
  - With the stuck-bit fault of the second scenario: fail_addr=3, fail_data=A7.
